bubble_multicycle_cpu: RTL and testbench
========================================

# bubble_multicycle_cpu

Parametrised multi-cycle successor to the single-cycle BUBBLE core. It executes the same MIPS-subset ISA through a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine. It uses one shared ALU and a single external memory port with a req/ready handshake, so both instruction and data memory can have wait states. It also adds halt, illegal-opcode trapping and a retire strobe for the bench and system integration.

## Interface
- NREG, 32: architectural register count; power of 2, 2..32.
- ADDR_W, 16: byte-address width of the memory port; 8..32.
- RESET_PC, 0: PC loaded on reset; must be word aligned.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  byte address; bits [1:0] always 0.
- mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  in  32  read data; sampled on the edge where mem_ready=1.
- mem_ready  in  1  completes the current request; may be combinational.
- pc  out  ADDR_W  address of the instruction being executed.
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
- halted  out  1  core is in HALT; sticky until rst.
- illegal  out  1  HALT was entered on an unsupported opcode/funct; sticky until rst.

## Operation
- Supported instructions:
  - R-type (op 0): funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, halt 0x3F.
- All arithmetic is 32-bit two's complement and wraps; there are no overflow traps.
- imm16 is sign-extended to 32 bits.
- Effective address = rs + sext(imm). Only bits [ADDR_W-1:2] drive mem_addr; bits [1:0] are forced to 0.
- beq target = PC+4 + (sext(imm)<<2), truncated to ADDR_W.
- j target = {(PC+4)[ADDR_W-1:28 if ADDR_W>28], imm26<<2}, truncated to ADDR_W.
- Register file:
  - r0 reads 0 and writes to it are dropped.
  - Indices ≥ NREG read 0 and writes to them are dropped.
  - All registers clear to 0 on rst.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt]. Decode the opcode.
    - halt → HALT.
    - Unknown op or funct → HALT with illegal=1.
    - j → PC<=target, retire, → FETCH.
    - Otherwise → EXEC.
  - EXEC:
    - R-type/addi: ALUOut<=result → WB.
    - lw/sw: ALUOut<=address → MEM.
    - beq: if A==B then PC<=target; retire; → FETCH.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B. On mem_ready:
    - lw: MDR<=rdata → WB.
    - sw: retire → FETCH.
  - WB: write ALUOut (R-type to rd, addi to rt) or MDR (lw to rt). Retire, → FETCH.
  - HALT: mem_req=0, stay until rst.
- While waiting for mem_ready, mem_req, mem_we, mem_addr and mem_wdata hold stable.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pc=RESET_PC, retire=0, halted=0, illegal=0, state=FETCH.
- mem_req rises in the first cycle after rst is deasserted.
- rst asserted in any state, including mid-handshake, aborts the instruction on that edge. A pending request is dropped with no register or PC side effects from that instruction.
- Latency with zero-wait memory (mem_ready=1 combinationally):
  - j: 2 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds exactly 1 cycle.
- retire is asserted in the last state's cycle. The architectural effect (register write or PC update) is visible on the following cycle.
- mem_ready while mem_req=0 is ignored.
- The transfer completes on the edge where mem_req=1 and mem_ready=1 are both sampled. The next request starts no earlier than the next cycle.
- A register written by WB is readable by the next instruction's DECODE; no bypass is needed.
- halted and illegal assert in the cycle after DECODE of the offending instruction.
- PC wraps modulo 2^ADDR_W.

## Test plan
- Reset with zero-wait memory holding addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt. Required: r3=2, 4 retire pulses, halted=1, illegal=0, PC=0x10 at halt.
- sw r1,8(r0) then lw r4,8(r0) with r1=0xDEADBEEF and memory ready delayed 3 cycles per request. Required:
  - write seen at addr 8 with wdata 0xDEADBEEF;
  - r4=0xDEADBEEF;
  - lw takes 5+6 cycles;
  - address, we and wdata stable through all wait cycles.
- beq loop counting r1 from 3 to 0 with addi r1,r1,-1, then a taken branch back by -2. Required: exactly 3 taken-branch iterations; fall-through at the correct PC+4.
- slt signed check: r1=0xFFFFFFFF, r2=1, slt r3,r1,r2 gives r3=1. sub r4,r2,r1 gives 2. add of 0x7FFFFFFF+1 wraps to 0x80000000 with no trap.
- Unknown opcode 0x3E at PC 0x0C. Required: illegal=1, halted=1, mem_req stays 0 afterwards, PC=0x10.
- Assert rst during the MEM wait of a sw. Required: the write never completes, all registers read 0, and a fresh fetch from RESET_PC follows. With NREG=8, writes to r9 are dropped and reads of r9 return 0.

Source files
------------

// File: rtl/bubble_multicycle_cpu.sv
// BUBBLE multi-cycle core: FETCH/DECODE/EXEC/MEM/WB state machine over one shared
// ALU and a single req/ready memory port used for both instruction and data access.
module bubble_multicycle_cpu #(
    parameter int                NREG     = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state, state_next;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       regs [1:NREG-1];
    logic [31:0]       rs_val, rt_val, imm_sext, alu_b, alu_result, wdata;
    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, waddr;
    logic              is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, is_halt, funct_ok, legal;
    logic [ADDR_W-1:0] br_target, j_target;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    assign is_rtype = (op == OP_R);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_addi  = (op == OP_ADDI);
    assign is_j     = (op == OP_J);
    assign is_halt  = (op == OP_HALT);
    assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT);
    assign legal    = (is_rtype && funct_ok) || is_lw || is_sw || is_beq || is_addi || is_j || is_halt;

    // pc already holds PC+4 once the instruction has been fetched.
    assign br_target = pc + ADDR_W'(imm_sext << 2);
    if (ADDR_W > 28) begin : g_j_wide
        assign j_target = {pc[ADDR_W-1:28], ir[25:0], 2'b00};
    end else begin : g_j_narrow
        assign j_target = ADDR_W'({ir[25:0], 2'b00});
    end

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs == 5'(i)) rs_val = regs[i];
            if (rt == 5'(i)) rt_val = regs[i];
        end
    end

    always_comb begin
        alu_b      = is_rtype ? b : imm_sext;
        alu_result = a + alu_b;
        if (is_rtype) begin
            case (funct)
                F_SUB:   alu_result = a - alu_b;
                F_AND:   alu_result = a & alu_b;
                F_OR:    alu_result = a | alu_b;
                F_SLT:   alu_result = {31'd0, $signed(a) < $signed(alu_b)};
                default: ;
            endcase
        end
    end

    assign waddr = is_rtype ? rd : rt;
    assign wdata = is_lw ? mdr : alu_out;

    // NOTE: the register file is reset explicitly because software relies on all
    // registers reading 0 after rst, not only r0.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREG; i++) begin
            if (rst)
                regs[i] <= '0;
            else if (state == S_WB && waddr == 5'(i))
                regs[i] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (is_halt || !legal) state_next = S_HALT;
                else if (is_j)         state_next = S_FETCH;
                else                   state_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_beq)              state_next = S_FETCH;
                else if (is_lw || is_sw) state_next = S_MEM;
                else                     state_next = S_WB;
            end
            S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Outputs are masked during rst so a request caught mid-handshake is dropped
    // on the aborting edge instead of completing.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = {pc[ADDR_W-1:2], 2'b00};
                end
                S_DECODE: retire = is_j || is_halt;
                S_EXEC:   retire = is_beq;
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = is_sw;
                    mem_addr  = {alu_out[ADDR_W-1:2], 2'b00};
                    mem_wdata = is_sw ? b : '0;
                    retire    = is_sw && mem_ready;
                end
                S_WB:     retire = 1'b1;
                S_HALT:   halted = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + ADDR_W'(4);
                end
                S_DECODE: begin
                    a <= rs_val;
                    b <= rt_val;
                    if (is_j)   pc      <= j_target;
                    if (!legal) illegal <= 1'b1;
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    if (is_beq && a == b) pc <= br_target;
                end
                S_MEM:   if (mem_ready && is_lw) mdr <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_multicycle_cpu.sv
// Self-checking bench for bubble_multicycle_cpu: wait-state memory model, store and
// retire-latency scoreboards, reset/abort and illegal-opcode scenarios.
module tb_bubble_multicycle_cpu;

    localparam int                ADDR_W   = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam int F_ADD = 'h20, F_SUB = 'h22, F_AND = 'h24, F_OR = 'h25, F_SLT = 'h2A;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req, mem_we, mem_ready, retire, halted, illegal;
    logic [ADDR_W-1:0] mem_addr, pc;
    logic [31:0]       mem_wdata, mem_rdata;

    bubble_multicycle_cpu #(.NREG(8), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Memory model: program image plus a write overlay, ready after wait_cycles.
    logic [31:0] prog   [64];
    logic [31:0] wr_mem [64];
    logic [63:0] wr_valid = '0;
    logic        mem_clear = 1'b0;
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    logic [5:0]  widx;

    assign widx      = mem_addr[7:2];
    assign mem_rdata = wr_valid[widx] ? wr_mem[widx] : prog[widx];
    assign mem_ready = mem_req && (wait_cnt >= wait_cycles);

    always @(posedge clk) begin
        if (mem_clear) wr_valid <= '0;
        if (mem_req && mem_ready) begin
            wait_cnt <= 0;
            if (mem_we) begin
                wr_mem[widx]   <= mem_wdata;
                wr_valid[widx] <= 1'b1;
            end
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              last_ret = 0;
    int              n_ret = 0;
    logic            prev_wait = 1'b0;
    logic            prev_we = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0]     prev_wdata = '0;
    logic [63:0]     st_q [$];
    int              lat_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input int fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int target);
        return {OP_J, 26'(target >> 2)};
    endfunction

    function automatic logic [31:0] halt_ins();
        return {OP_HALT, 26'd0};
    endfunction

    // Cycles from first fetch cycle to retire, per instruction class.
    function automatic int lat_of(input logic [31:0] ins, input int w);
        logic [5:0] op;
        op = ins[31:26];
        case (op)
            OP_J, OP_HALT: return 2 + w;
            OP_BEQ:        return 3 + w;
            OP_SW:         return 4 + 2 * w;
            OP_LW:         return 5 + 2 * w;
            default:       return 4 + w;
        endcase
    endfunction

    task automatic monitor();
        logic [63:0] exp;
        if (rst) begin
            cyc = 0; last_ret = 0; n_ret = 0; prev_wait = 1'b0;
            return;
        end
        cyc++;
        if (prev_wait) begin
            check("hold_req", mem_req, 1);
            check("hold_addr", mem_addr, prev_addr);
            check("hold_we", mem_we, prev_we);
            check("hold_wdata", mem_wdata, prev_wdata);
        end
        prev_wait  = mem_req && !mem_ready;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        if (mem_req && mem_ready && mem_we) begin
            exp = (st_q.size() > 0) ? st_q.pop_front() : '1;
            check("store", {16'd0, mem_addr, mem_wdata}, exp);
        end
        if (retire) begin
            n_ret++;
            check("latency", 64'(cyc - last_ret), (lat_q.size() > 0) ? 64'(lat_q.pop_front()) : '1);
            last_ret = cyc;
        end
        if (halted) check("halt_req", mem_req, 0);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test(input int w);
        wait_cycles = w;
        for (int i = 0; i < 64; i++) prog[i] = '0;
        st_q.delete();
        lat_q.delete();
    endtask

    task automatic expect_path(input int idx);
        lat_q.push_back(lat_of(prog[idx], wait_cycles));
    endtask

    task automatic expect_store(input int addr, input logic [31:0] data);
        st_q.push_back({32'(addr), data});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_clear = 1'b1;
        step();
        step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_pc", pc, RESET_PC);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        mem_clear = 1'b0;
        #1;
        check("first_fetch_req", mem_req, 1);
        check("first_fetch_we", mem_we, 0);
        check("first_fetch_addr", mem_addr, RESET_PC);
    endtask

    task automatic finish_test(input logic exp_ill, input int exp_pc, input int exp_ret);
        for (int i = 0; i < 2000 && !halted; i++) step();
        check("halt_reached", halted, 1);
        for (int i = 0; i < 4; i++) step();
        check("halted", halted, 1);
        check("illegal", illegal, exp_ill);
        check("pc_at_halt", pc, exp_pc);
        check("retire_count", n_ret, exp_ret);
        check("stores_left", st_q.size(), 0);
        check("retires_left", lat_q.size(), 0);
    endtask

    initial begin
        int found;

        // addi/addi/add/halt with zero-wait memory.
        begin_test(0);
        prog[0] = i_ins(OP_ADDI, 1, 0, 5);
        prog[1] = i_ins(OP_ADDI, 2, 0, -3);
        prog[2] = r_ins(F_ADD, 3, 1, 2);
        prog[3] = halt_ins();
        for (int i = 0; i < 4; i++) expect_path(i);
        do_reset();
        finish_test(1'b0, 'h10, 4);

        // Same sequence with r3 stored out for inspection.
        begin_test(0);
        prog[0] = i_ins(OP_ADDI, 1, 0, 5);
        prog[1] = i_ins(OP_ADDI, 2, 0, -3);
        prog[2] = r_ins(F_ADD, 3, 1, 2);
        prog[3] = i_ins(OP_SW, 3, 0, 'h40);
        prog[4] = halt_ins();
        for (int i = 0; i < 5; i++) expect_path(i);
        expect_store('h40, 32'd2);
        do_reset();
        finish_test(1'b0, 'h14, 5);

        // Store/load round trip with three wait cycles per request.
        begin_test(3);
        prog[0]  = j_ins('h20);
        prog[8]  = i_ins(OP_LW, 1, 0, 'h40);
        prog[9]  = i_ins(OP_SW, 1, 0, 8);
        prog[10] = i_ins(OP_LW, 4, 0, 8);
        prog[11] = i_ins(OP_SW, 4, 0, 'h44);
        prog[12] = halt_ins();
        prog[16] = 32'hDEADBEEF;
        expect_path(0);
        for (int i = 8; i <= 12; i++) expect_path(i);
        expect_store(8, 32'hDEADBEEF);
        expect_store('h44, 32'hDEADBEEF);
        do_reset();
        finish_test(1'b0, 'h34, 6);

        // Countdown loop: three taken back-branches, then exit.
        begin_test(0);
        prog[0] = i_ins(OP_ADDI, 1, 0, 3);
        prog[1] = i_ins(OP_BEQ, 0, 1, 3);
        prog[2] = i_ins(OP_ADDI, 1, 1, -1);
        prog[3] = i_ins(OP_ADDI, 2, 2, 1);
        prog[4] = i_ins(OP_BEQ, 0, 0, -4);
        prog[5] = i_ins(OP_SW, 2, 0, 'h40);
        prog[6] = i_ins(OP_SW, 1, 0, 'h44);
        prog[7] = halt_ins();
        expect_path(0);
        for (int it = 0; it < 3; it++)
            for (int i = 1; i <= 4; i++) expect_path(i);
        for (int i = 1; i <= 7; i++) if (i < 2 || i > 4) expect_path(i);
        expect_store('h40, 32'd3);
        expect_store('h44, 32'd0);
        do_reset();
        finish_test(1'b0, 'h20, 17);

        // Signed compare, subtract, wrap-around add, logic ops; one wait cycle.
        begin_test(1);
        prog[0]  = i_ins(OP_ADDI, 1, 0, -1);
        prog[1]  = i_ins(OP_ADDI, 2, 0, 1);
        prog[2]  = r_ins(F_SLT, 3, 1, 2);
        prog[3]  = i_ins(OP_SW, 3, 0, 'h80);
        prog[4]  = r_ins(F_SUB, 4, 2, 1);
        prog[5]  = i_ins(OP_SW, 4, 0, 'h84);
        prog[6]  = r_ins(F_SLT, 3, 2, 1);
        prog[7]  = i_ins(OP_SW, 3, 0, 'h88);
        prog[8]  = i_ins(OP_LW, 5, 0, 'hC0);
        prog[9]  = r_ins(F_ADD, 6, 5, 2);
        prog[10] = i_ins(OP_SW, 6, 0, 'h8C);
        prog[11] = r_ins(F_AND, 7, 5, 1);
        prog[12] = i_ins(OP_SW, 7, 0, 'h90);
        prog[13] = r_ins(F_OR, 7, 2, 4);
        prog[14] = i_ins(OP_SW, 7, 0, 'h94);
        prog[15] = halt_ins();
        prog[48] = 32'h7FFFFFFF;
        for (int i = 0; i < 16; i++) expect_path(i);
        expect_store('h80, 32'd1);
        expect_store('h84, 32'd2);
        expect_store('h88, 32'd0);
        expect_store('h8C, 32'h80000000);
        expect_store('h90, 32'h7FFFFFFF);
        expect_store('h94, 32'd3);
        do_reset();
        finish_test(1'b0, 'h40, 16);

        // Unknown opcode 0x3E at 0x0C.
        begin_test(0);
        prog[0] = i_ins(OP_ADDI, 1, 0, 1);
        prog[1] = i_ins(OP_ADDI, 2, 0, 2);
        prog[2] = i_ins(OP_ADDI, 3, 0, 3);
        prog[3] = {6'h3E, 26'd0};
        for (int i = 0; i < 3; i++) expect_path(i);
        do_reset();
        finish_test(1'b1, 'h10, 3);

        // Unknown R-type funct traps too.
        begin_test(2);
        prog[0] = r_ins('h21, 1, 0, 0);
        do_reset();
        finish_test(1'b1, 'h04, 0);

        // Reset during the wait of a store; r9 is outside an 8-entry file.
        begin_test(3);
        prog[0] = i_ins(OP_SW, 1, 0, 'h44);
        prog[1] = i_ins(OP_ADDI, 1, 0, 7);
        prog[2] = i_ins(OP_SW, 1, 0, 'h40);
        prog[3] = i_ins(OP_ADDI, 9, 0, 77);
        prog[4] = i_ins(OP_SW, 9, 0, 'h48);
        prog[5] = halt_ins();
        expect_path(0);
        expect_path(1);
        expect_store('h44, 32'd0);
        expect_store('h44, 32'd0);
        expect_store('h40, 32'd7);
        expect_store('h48, 32'd0);
        do_reset();
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (mem_req && mem_we && !mem_ready && mem_addr == ADDR_W'('h40)) found = 1;
        end
        check("abort_point", found, 1);
        do_reset();
        check("retires_before_restart", lat_q.size(), 0);
        for (int i = 0; i < 6; i++) expect_path(i);
        finish_test(1'b0, 'h18, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
